// File: rtl/ctrl_req_arb.sv
// ctrl_req_arb: round-robin request arbiter in front of the single-transaction DDR4
// controller command path. Accepts one host request at a time, presents it as a
// latched command, and waits for the controller's completion pulse before granting
// again. A pending refresh blocks new grants but never an in-flight transaction.
//
// Optional build macro: ARB_RD_PRIORITY_EN. When defined, reads are preferred over
// writes, and a starve counter bounded by STARVE_MAX forces a write grant. When it is
// undefined, arbitration is plain round-robin and the starve logic is not built.
//
// Ports:
//   CK_t        - clock, rising edge
//   reset_n     - asynchronous active-low reset
//   req_valid   - per-port request valid
//   req_rw      - per-port direction (1 = read, 0 = write)
//   req_addr    - per-port address, port i at [i*ADDR_W +: ADDR_W]
//   req_ready   - one-hot accept strobe, only in IDLE
//   cmd_valid   - command offered to the controller (ISSUE state)
//   cmd_rw      - latched direction
//   cmd_addr    - latched address
//   cmd_id      - latched index of the granted port
//   cmd_ack     - controller took the command
//   cmd_done    - one-cycle end-of-burst pulse
//   refresh_req - refresh pending; blocks new grants in IDLE
//   arb_busy    - high whenever the FSM is not in IDLE
module ctrl_req_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = $clog2(NUM_REQ),
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                      CK_t,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cmd_valid,
  output logic                      cmd_rw,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [ID_W-1:0]           cmd_id,
  input  logic                      cmd_ack,
  input  logic                      cmd_done,
  input  logic                      refresh_req,
  output logic                      arb_busy
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("ctrl_req_arb: NUM_REQ must be at least 2");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("ctrl_req_arb: STARVE_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     w_rr_ptr_next;
  logic                r_cmd_rw;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [ID_W-1:0]     r_cmd_id;

  logic [NUM_REQ-1:0]  w_elig;     // ports allowed to compete this cycle
  logic                w_found;
  logic [ID_W-1:0]     w_win;
  logic                w_grant;
  logic                w_sel_rw;
  logic [ADDR_W-1:0]   w_sel_addr;

  // --------------------------------------------------------------------------
  // Request class filtering
  // --------------------------------------------------------------------------
`ifdef ARB_RD_PRIORITY_EN
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  logic [StarveW-1:0] r_starve;
  logic [StarveW-1:0] w_starve_next;
  logic               w_rd_any;
  logic               w_wr_any;

  assign w_rd_any = |(req_valid & req_rw);
  assign w_wr_any = |(req_valid & ~req_rw);

  // Reads win while the starve budget lasts; once exhausted, a waiting write wins.
  always_comb begin
    w_elig = req_valid;
    if (w_rd_any && (r_starve < StarveMax)) begin
      w_elig = req_valid & req_rw;
    end else if (w_wr_any && (r_starve == StarveMax)) begin
      w_elig = req_valid & ~req_rw;
    end
  end

  always_comb begin
    w_starve_next = r_starve;
    if (r_state == StIdle) begin
      if (!w_wr_any) begin
        w_starve_next = '0;
      end else if (w_grant) begin
        if (!w_sel_rw) begin
          w_starve_next = '0;
        end else if (r_starve != StarveMax) begin
          w_starve_next = r_starve + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_next;
    end
  end
`else
  assign w_elig = req_valid;
`endif

  // --------------------------------------------------------------------------
  // Round-robin search: the winner is the eligible port at the smallest
  // circular distance from rr_ptr.
  // --------------------------------------------------------------------------
  always_comb begin
    int v_ptr;
    int v_dist;
    int v_best;
    v_ptr   = int'(32'(r_rr_ptr));
    v_dist  = 0;
    v_best  = int'(NUM_REQ);
    w_found = 1'b0;
    w_win   = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      v_dist = (j >= v_ptr) ? (j - v_ptr) : (j + int'(NUM_REQ) - v_ptr);
      if (w_elig[j] && (v_dist < v_best)) begin
        v_best  = v_dist;
        w_found = 1'b1;
        w_win   = ID_W'(j);
      end
    end
  end

  assign w_grant = (r_state == StIdle) && !refresh_req && w_found;

  // Winner's direction/address mux and one-hot ready.
  always_comb begin
    w_sel_rw   = 1'b0;
    w_sel_addr = '0;
    req_ready  = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (w_win == ID_W'(j)) begin
        w_sel_rw     = req_rw[j];
        w_sel_addr   = req_addr[j*ADDR_W +: ADDR_W];
        req_ready[j] = w_grant;
      end
    end
  end

  // Pointer moves just past the granted port, wrapping at NUM_REQ-1.
  always_comb begin
    w_rr_ptr_next = r_rr_ptr;
    if (w_grant) begin
      if (32'(w_win) == (NUM_REQ - 1)) begin
        w_rr_ptr_next = '0;
      end else begin
        w_rr_ptr_next = w_win + ID_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        // cmd_done here is stray and deliberately ignored.
        if (cmd_ack) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (cmd_done) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_cmd_rw   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_id   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
      if (w_grant) begin
        r_cmd_rw   <= w_sel_rw;
        r_cmd_addr <= w_sel_addr;
        r_cmd_id   <= w_win;
      end
    end
  end

  // Decoded straight from the state register so reset clears them asynchronously.
  assign cmd_valid = (r_state == StIssue);
  assign arb_busy  = (r_state != StIdle);
  assign cmd_rw    = r_cmd_rw;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_id    = r_cmd_id;

endmodule
